radix3_bfly_pipe: RTL

Parametrised, pipelined radix-3 DFT butterfly for the mixed-radix FFT datapath. It takes three complex two's-complement fixed-point samples per beat and produces the three DFT outputs with exact bit growth. It supports forward and inverse transform per beat. A valid/ready handshake with full backpressure lets it sit between FFT stage buffers and twiddle multipliers.

---
 rtl/fft_pkg.sv | 36 +++
 rtl/const_mult_round.sv | 30 +++
 rtl/radix3_bfly_pipe.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the mixed-radix FFT datapath.
// Holds the pipeline geometry of the radix-3 butterfly, the width helper
// that the radix-2/3/4 butterflies all use to size their outputs, and the
// elaboration-time computation of the sqrt(3)/2 twiddle constant.
package fft_pkg;

   localparam int unsigned NumStages  = 3;
   localparam int unsigned GrowthBits = 2;

   // Output component width of a butterfly whose inputs are data_w wide.
   function automatic int unsigned cplx_w(input int unsigned data_w,
                                          input int unsigned growth);
      return data_w + growth;
   endfunction

   // Floor integer square root; the argument stays well below 2^62.
   function automatic longint unsigned isqrt64(input longint unsigned n);
      longint unsigned r;
      longint unsigned cand;
      r = 0;
      for (int i = 31; i >= 0; i--) begin
         cand = r | (64'd1 << i);
         if (cand * cand <= n) r = cand;
      end
      return r;
   endfunction

   // K = round(sqrt(3)/2 * 2^(coef_w-1)), half-up.
   // isqrt(3 * 2^(2*coef_w-2)) = floor(2*K_exact), so (that + 1) >> 1 rounds K.
   function automatic int unsigned calc_k(input int unsigned coef_w);
      longint unsigned n;
      n = 64'd3 << (2 * coef_w - 2);
      return int'((isqrt64(n) + 64'd1) >> 1);
   endfunction

endpackage

// File: rtl/const_mult_round.sv
// Signed multiply by a fixed positive constant K with half-up rounding.
// p_o = (K * d_i + 2^(COEF_W-3)) >>> (COEF_W-2), i.e. 2*(K/2^(COEF_W-1))*d_i
// carrying one fractional bit. Purely combinational.
//   d_i : signed difference term, IN_W bits
//   p_o : rounded scaled product, OUT_W bits
module const_mult_round #(
   parameter int unsigned IN_W   = 17,
   parameter int unsigned COEF_W = 16,
   parameter int unsigned K      = 28378,
   parameter int unsigned OUT_W  = 18
) (
   input  logic signed [IN_W-1:0]  d_i,
   output logic signed [OUT_W-1:0] p_o
);

   localparam int unsigned ProdW = IN_W + COEF_W + 1;
   localparam int unsigned Shift = COEF_W - 2;
   localparam logic signed [ProdW-1:0] KConst = ProdW'(K);
   localparam logic signed [ProdW-1:0] Half   = ProdW'(longint'(1) << (COEF_W - 3));

   logic signed [ProdW-1:0] prod;
   logic signed [ProdW-1:0] rnd;

   always_comb begin
      prod = ProdW'(d_i) * KConst;
      rnd  = (prod + Half) >>> Shift;
      p_o  = OUT_W'(rnd);
   end

endmodule

// File: rtl/radix3_bfly_pipe.sv
// Three-stage pipelined radix-3 DFT butterfly with valid/ready handshake.
// Stage 1: s = b+c, d = b-c.  Stage 2: X0 = a+s, h = 2a-s, p = sqrt(3)*d.
// Stage 3: rotate/combine h and p into X1/X2 with half-up rounding.
// All stages share one enable, so a stall freezes the whole pipe.
//   clk, rst             : clock, async active-high reset
//   in_valid/in_ready    : input handshake; inv selects inverse per beat
//   a_*, b_*, c_*        : complex input samples, DATA_W bits signed
//   out_valid/out_ready  : output handshake
//   x0_*, x1_*, x2_*     : DFT outputs, OUT_W bits signed
module radix3_bfly_pipe
   import fft_pkg::*;
#(
   parameter int unsigned  DATA_W = 16,
   parameter int unsigned  COEF_W = 16,
   localparam int unsigned OUT_W  = cplx_w(DATA_W, GrowthBits)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     inv,
   input  logic signed [DATA_W-1:0] a_re,
   input  logic signed [DATA_W-1:0] a_im,
   input  logic signed [DATA_W-1:0] b_re,
   input  logic signed [DATA_W-1:0] b_im,
   input  logic signed [DATA_W-1:0] c_re,
   input  logic signed [DATA_W-1:0] c_im,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [OUT_W-1:0]  x0_re,
   output logic signed [OUT_W-1:0]  x0_im,
   output logic signed [OUT_W-1:0]  x1_re,
   output logic signed [OUT_W-1:0]  x1_im,
   output logic signed [OUT_W-1:0]  x2_re,
   output logic signed [OUT_W-1:0]  x2_im
);

   localparam int unsigned SumW = DATA_W + 1;
   localparam int unsigned HW   = DATA_W + 3;
   localparam int unsigned PW   = DATA_W + 2;
   localparam int unsigned TW   = DATA_W + 4;
   localparam int unsigned K    = calc_k(COEF_W);
   localparam logic signed [TW-1:0] RndOne = TW'(1);

   logic [NumStages-1:0] vld_q;
   logic                 adv;

   // Stage 1
   logic signed [SumW-1:0]   s_re_d, s_im_d, d_re_d, d_im_d;
   logic signed [SumW-1:0]   s_re_q, s_im_q, d_re_q, d_im_q;
   logic signed [DATA_W-1:0] a_re_q, a_im_q;
   logic                     inv1_q;

   // Stage 2
   logic signed [OUT_W-1:0] x0s_re_d, x0s_im_d, x0s_re_q, x0s_im_q;
   logic signed [HW-1:0]    h_re_d, h_im_d, h_re_q, h_im_q;
   logic signed [PW-1:0]    p_re_d, p_im_d, p_re_q, p_im_q;
   logic                    inv2_q;

   // Stage 3
   logic signed [TW-1:0]    t_rp, t_rm, t_ip, t_im;
   logic signed [OUT_W-1:0] y0_re_d, y0_im_d, y1_re_d, y1_im_d, y2_re_d, y2_im_d;
   logic signed [OUT_W-1:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q, y2_re_q, y2_im_q;

   assign adv       = !vld_q[NumStages-1] || out_ready;
   assign in_ready  = adv;
   assign out_valid = vld_q[NumStages-1];

   const_mult_round #(
      .IN_W   (SumW),
      .COEF_W (COEF_W),
      .K      (K),
      .OUT_W  (PW)
   ) u_mult_re (
      .d_i (d_re_q),
      .p_o (p_re_d)
   );

   const_mult_round #(
      .IN_W   (SumW),
      .COEF_W (COEF_W),
      .K      (K),
      .OUT_W  (PW)
   ) u_mult_im (
      .d_i (d_im_q),
      .p_o (p_im_d)
   );

   always_comb begin
      s_re_d   = SumW'(b_re) + SumW'(c_re);
      s_im_d   = SumW'(b_im) + SumW'(c_im);
      d_re_d   = SumW'(b_re) - SumW'(c_re);
      d_im_d   = SumW'(b_im) - SumW'(c_im);

      x0s_re_d = OUT_W'(a_re_q) + OUT_W'(s_re_q);
      x0s_im_d = OUT_W'(a_im_q) + OUT_W'(s_im_q);
      h_re_d   = (HW'(a_re_q) <<< 1) - HW'(s_re_q);
      h_im_d   = (HW'(a_im_q) <<< 1) - HW'(s_im_q);

      t_rp     = TW'(h_re_q) + TW'(p_im_q) + RndOne;
      t_rm     = TW'(h_re_q) - TW'(p_im_q) + RndOne;
      t_ip     = TW'(h_im_q) + TW'(p_re_q) + RndOne;
      t_im     = TW'(h_im_q) - TW'(p_re_q) + RndOne;

      y0_re_d  = x0s_re_q;
      y0_im_d  = x0s_im_q;
      // Inverse transform conjugates W, which simply swaps the X1/X2 formulas.
      y1_re_d  = OUT_W'(inv2_q ? (t_rm >>> 1) : (t_rp >>> 1));
      y1_im_d  = OUT_W'(inv2_q ? (t_ip >>> 1) : (t_im >>> 1));
      y2_re_d  = OUT_W'(inv2_q ? (t_rp >>> 1) : (t_rm >>> 1));
      y2_im_d  = OUT_W'(inv2_q ? (t_im >>> 1) : (t_ip >>> 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q    <= '0;
         s_re_q   <= '0;
         s_im_q   <= '0;
         d_re_q   <= '0;
         d_im_q   <= '0;
         a_re_q   <= '0;
         a_im_q   <= '0;
         inv1_q   <= 1'b0;
         x0s_re_q <= '0;
         x0s_im_q <= '0;
         h_re_q   <= '0;
         h_im_q   <= '0;
         p_re_q   <= '0;
         p_im_q   <= '0;
         inv2_q   <= 1'b0;
         y0_re_q  <= '0;
         y0_im_q  <= '0;
         y1_re_q  <= '0;
         y1_im_q  <= '0;
         y2_re_q  <= '0;
         y2_im_q  <= '0;
      end else if (adv) begin
         vld_q    <= {vld_q[NumStages-2:0], in_valid};
         s_re_q   <= s_re_d;
         s_im_q   <= s_im_d;
         d_re_q   <= d_re_d;
         d_im_q   <= d_im_d;
         a_re_q   <= a_re;
         a_im_q   <= a_im;
         inv1_q   <= inv;
         x0s_re_q <= x0s_re_d;
         x0s_im_q <= x0s_im_d;
         h_re_q   <= h_re_d;
         h_im_q   <= h_im_d;
         p_re_q   <= p_re_d;
         p_im_q   <= p_im_d;
         inv2_q   <= inv1_q;
         y0_re_q  <= y0_re_d;
         y0_im_q  <= y0_im_d;
         y1_re_q  <= y1_re_d;
         y1_im_q  <= y1_im_d;
         y2_re_q  <= y2_re_d;
         y2_im_q  <= y2_im_d;
      end
   end

   assign x0_re = y0_re_q;
   assign x0_im = y0_im_q;
   assign x1_re = y1_re_q;
   assign x1_im = y1_im_q;
   assign x2_re = y2_re_q;
   assign x2_im = y2_im_q;

endmodule
